// File: rtl/debug_loader.sv
// debug_loader: UART-driven debug front end for the pipeline.
// Receives single-byte commands and program bytes, assembles instruction
// words MSB first for the instruction memory, and gates pipeline execution
// in free-run or single-step mode.
//
// Optional feature: define DEBUG_LOADER_TIMEOUT_EN to abort a load after
// TIMEOUT idle cycles, discarding the partial word and pulsing o_error.
// Without the macro the loader waits indefinitely and o_error is tied low.
//
// Byte handshake: i_rx_data is consumed on every rising edge of i_clk where
// i_rx_done=1 (one strobe = one byte). There is no backpressure; every
// strobe is taken in the cycle it appears. o_write is a one-cycle strobe
// with o_instruction held stable while it is high.
module debug_loader #(
    parameter int INST_SZ = 32,
    parameter int BYTE_SZ = 8,
    parameter int MEM_SZ  = 10,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_halt,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_write,
    output logic               o_enable,
    output logic [MEM_SZ:0]    o_inst_count,
    output logic [2:0]         o_state,
    output logic               o_error
);

    localparam int BPW   = INST_SZ / BYTE_SZ;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [MEM_SZ:0]   CNT_ONE  = (MEM_SZ + 1)'(1);
    // Word count at which the memory is full (2^MEM_SZ).
    localparam logic [MEM_SZ:0]   CAP      = {1'b1, {MEM_SZ{1'b0}}};

    localparam logic [BYTE_SZ-1:0] CMD_LOAD  = BYTE_SZ'(8'h4C);
    localparam logic [BYTE_SZ-1:0] CMD_RUN   = BYTE_SZ'(8'h43);
    localparam logic [BYTE_SZ-1:0] CMD_STEP  = BYTE_SZ'(8'h53);
    localparam logic [BYTE_SZ-1:0] CMD_NEXT  = BYTE_SZ'(8'h4E);
    localparam logic [BYTE_SZ-1:0] CMD_EXIT  = BYTE_SZ'(8'h45);
    localparam logic [BYTE_SZ-1:0] CMD_RESET = BYTE_SZ'(8'h52);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q;
    logic [INST_SZ-1:0] word_q;
    logic [INST_SZ-1:0] word_d;
    logic [INST_SZ-1:0] instr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [MEM_SZ:0]    count_q;
    logic [MEM_SZ:0]    count_d;
    logic               write_q;
    logic               enable_q;

`ifdef DEBUG_LOADER_TIMEOUT_EN
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_q;
    logic            error_q;

    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    // Next partial word (incoming byte shifted in at the LSB end) and next word count.
    always_comb begin
        word_d  = {word_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};
        count_d = count_q + CNT_ONE;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            instr_q  <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            write_q  <= 1'b0;
            enable_q <= 1'b0;
`ifdef DEBUG_LOADER_TIMEOUT_EN
            to_cnt_q <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            write_q  <= 1'b0;
            enable_q <= 1'b0;
`ifdef DEBUG_LOADER_TIMEOUT_EN
            error_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state_q <= S_LOAD;
                                count_q <= '0;
                                idx_q   <= '0;
                                word_q  <= '0;
`ifdef DEBUG_LOADER_TIMEOUT_EN
                                to_cnt_q <= '0;
`endif
                            end
                            CMD_RUN: begin
                                state_q  <= S_RUN;
                                enable_q <= 1'b1;
                            end
                            CMD_STEP: state_q <= S_STEP;
                            default: ;
                        endcase
                    end
                end

                S_LOAD: begin
                    if (i_rx_done) begin
                        word_q <= word_d;
`ifdef DEBUG_LOADER_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            instr_q <= word_d;
                            write_q <= 1'b1;
                            count_q <= count_d;
                            // HALT word or full memory ends the load.
                            if ((word_d == '1) || (count_d == CAP)) begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
`ifdef DEBUG_LOADER_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        state_q  <= S_IDLE;
                        error_q  <= 1'b1;
                        idx_q    <= '0;
                        word_q   <= '0;
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_ONE;
                    end
`endif
                end

                S_RUN: begin
                    if (i_halt) begin
                        state_q <= S_DONE;
                    end else begin
                        enable_q <= 1'b1;
                    end
                end

                S_STEP: begin
                    // Halt takes priority over a simultaneous step byte.
                    if (i_halt) begin
                        state_q <= S_DONE;
                    end else if (i_rx_done) begin
                        if (i_rx_data == CMD_NEXT) begin
                            enable_q <= 1'b1;
                        end else if (i_rx_data == CMD_EXIT) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_DONE: begin
                    if (i_rx_done && (i_rx_data == CMD_RESET)) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_instruction = instr_q;
    assign o_write       = write_q;
    assign o_enable      = enable_q;
    assign o_inst_count  = count_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: directed checks of debug_loader command decoding, word
// assembly, run/step enable generation, reset behaviour and load capacity.
// Memory depth is reduced to 8 words so the full-memory case is reachable.
module tb_debug_loader;

    localparam int INST = 32;
    localparam int BYTE = 8;
    localparam int MEM  = 3;
    localparam int TO   = 16;

    logic             clk;
    logic             rst_n;
    logic [BYTE-1:0]  rx_data;
    logic             rx_done;
    logic             halt;
    logic [INST-1:0]  instruction;
    logic             write;
    logic             enable;
    logic [MEM:0]     inst_count;
    logic [2:0]       state;
    logic             error;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int base;

    debug_loader #(
        .INST_SZ(INST),
        .BYTE_SZ(BYTE),
        .MEM_SZ (MEM),
        .TIMEOUT(TO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_halt       (halt),
        .o_instruction(instruction),
        .o_write      (write),
        .o_enable     (enable),
        .o_inst_count (inst_count),
        .o_state      (state),
        .o_error      (error)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (write)  wr_cnt++;
        if (enable) en_cnt++;
        if (error)  err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        halt    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state", 64'(state), 64'd0);
        check("rst_write", 64'(write), 64'd0);
        check("rst_enable", 64'(enable), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_instr", 64'(instruction), 64'd0);
        check("rst_count", 64'(inst_count), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_state", 64'(state), 64'd0);

        // First word 0x12345678
        send_byte(8'h4C);
        check("load_entry", 64'(state), 64'd1);
        check("load_count0", 64'(inst_count), 64'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check("no_write_3b", 64'(write), 64'd0);
        send_byte(8'h78);
        check("w1_write", 64'(write), 64'd1);
        check("w1_instr", 64'(instruction), 64'h12345678);
        check("w1_count", 64'(inst_count), 64'd1);
        check("w1_state", 64'(state), 64'd1);
        tick();
        check("w1_write_low", 64'(write), 64'd0);
        check("w1_instr_hold", 64'(instruction), 64'h12345678);

        // HALT word ends the load
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("halt_write", 64'(write), 64'd1);
        check("halt_instr", 64'(instruction), 64'hFFFFFFFF);
        check("halt_count", 64'(inst_count), 64'd2);
        check("halt_state", 64'(state), 64'd0);
        tick();
        check("halt_write_low", 64'(write), 64'd0);
        check("wr_total_2", 64'(wr_cnt), 64'd2);

        // Unknown bytes ignored in IDLE
        send_byte(8'h00);
        check("idle_ign_00", 64'(state), 64'd0);
        send_byte(8'h4E);
        check("idle_ign_4e", 64'(state), 64'd0);
        check("idle_no_en", 64'(enable), 64'd0);

        // RUN: halt during the 10th cycle -> exactly 10 enable cycles
        base = en_cnt;
        send_byte(8'h43);
        check("run_state", 64'(state), 64'd2);
        check("run_en_c1", 64'(enable), 64'd1);
        send_byte(8'h45);
        check("run_ign_byte", 64'(state), 64'd2);
        for (int i = 0; i < 8; i++) tick();
        halt = 1'b1;
        check("run_en_c10", 64'(enable), 64'd1);
        tick();
        halt = 1'b0;
        check("run_en_off", 64'(enable), 64'd0);
        check("run_done", 64'(state), 64'd4);
        tick();
        check("run_en_cycles", 64'(en_cnt - base), 64'd10);
        send_byte(8'h4C);
        check("done_ign_4c", 64'(state), 64'd4);
        check("done_cnt_kept", 64'(inst_count), 64'd2);
        send_byte(8'h52);
        check("done_to_idle", 64'(state), 64'd0);

        // STEP: two pulses then exit
        base = en_cnt;
        send_byte(8'h53);
        check("step_state", 64'(state), 64'd3);
        check("step_en0", 64'(enable), 64'd0);
        send_byte(8'h4E);
        check("step_p1", 64'(enable), 64'd1);
        tick();
        check("step_p1_end", 64'(enable), 64'd0);
        send_byte(8'h43);
        check("step_ign_43", 64'(state), 64'd3);
        send_byte(8'h4E);
        check("step_p2", 64'(enable), 64'd1);
        send_byte(8'h45);
        check("step_exit", 64'(state), 64'd0);
        check("step_exit_en", 64'(enable), 64'd0);
        tick();
        check("step_pulses", 64'(en_cnt - base), 64'd2);

        // STEP: halt and step byte together -> halt wins
        base = en_cnt;
        send_byte(8'h53);
        halt = 1'b1;
        send_byte(8'h4E);
        halt = 1'b0;
        check("race_state", 64'(state), 64'd4);
        check("race_no_en", 64'(enable), 64'd0);
        tick();
        check("race_pulses", 64'(en_cnt - base), 64'd0);
        send_byte(8'h52);

        // STEP: halt right after a step byte -> pulse completes, DONE
        base = en_cnt;
        send_byte(8'h53);
        send_byte(8'h4E);
        halt = 1'b1;
        check("pend_en", 64'(enable), 64'd1);
        tick();
        halt = 1'b0;
        check("pend_state", 64'(state), 64'd4);
        tick();
        check("pend_pulses", 64'(en_cnt - base), 64'd1);
        send_byte(8'h52);
        check("pend_idle", 64'(state), 64'd0);

        // Reset mid-load discards the partial word
        base = wr_cnt;
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 64'(state), 64'd0);
        check("async_rst_count", 64'(inst_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("rl_no_write", 64'(write), 64'd0);
        send_byte(8'h04);
        check("rl_write", 64'(write), 64'd1);
        check("rl_instr", 64'(instruction), 64'h01020304);
        check("rl_count", 64'(inst_count), 64'd1);
        tick();
        check("rl_one_write", 64'(wr_cnt - base), 64'd1);

        // Fill memory: 8 words total, then back to IDLE with no wrap
        for (int k = 2; k <= 8; k++) begin
            for (int j = 0; j < 4; j++) send_byte(8'(k));
        end
        check("full_write", 64'(write), 64'd1);
        check("full_instr", 64'(instruction), 64'h08080808);
        check("full_count", 64'(inst_count), 64'd8);
        check("full_state", 64'(state), 64'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        tick();
        check("full_writes", 64'(wr_cnt - base), 64'd8);
        check("full_cnt_kept", 64'(inst_count), 64'd8);

`ifdef DEBUG_LOADER_TIMEOUT_EN
        // Silence after a partial word -> error pulse 16 cycles after last byte
        base = wr_cnt;
        send_byte(8'h4C);
        send_byte(8'hAA);
        for (int i = 0; i < TO - 1; i++) tick();
        check("to_not_yet", 64'(error), 64'd0);
        check("to_still_load", 64'(state), 64'd1);
        tick();
        check("to_error", 64'(error), 64'd1);
        check("to_idle", 64'(state), 64'd0);
        tick();
        check("to_error_pulse", 64'(error), 64'd0);
        check("to_no_write", 64'(wr_cnt - base), 64'd0);
`else
        // No timeout: long silence keeps the partial word
        send_byte(8'h4C);
        send_byte(8'hAA);
        for (int i = 0; i < 40; i++) tick();
        check("nto_state", 64'(state), 64'd1);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("nto_write", 64'(write), 64'd1);
        check("nto_instr", 64'(instruction), 64'hAABBCCDD);
        tick();
        check("nto_no_error", 64'(err_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 SHALL have parameter INST_SZ, default 32: instruction word width.
REQ-002 SHALL have parameter BYTE_SZ, default 8: received byte width.
REQ-003 SHALL have parameter MEM_SZ, default 10: instruction memory word address width; capacity 2^MEM_SZ words.
REQ-004 SHALL have parameter TIMEOUT, default 1_000_000: inter-byte timeout in cycles (used only with DEBUG_LOADER_TIMEOUT_EN).
REQ-005 SHALL have port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port i_reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port i_rx_data, input, BYTE_SZ: byte from UART receiver; valid only while i_rx_done=1.
REQ-008 SHALL have port i_rx_done, input, 1: one-cycle strobe; one strobe = one byte.
REQ-009 SHALL have port i_halt, input, 1: halt indication from the pipeline write-back stage.
REQ-010 SHALL have port o_instruction, output, INST_SZ: assembled word, stable while o_write=1.
REQ-011 SHALL have port o_write, output, 1: instruction memory write strobe, one cycle per word.
REQ-012 SHALL have port o_enable, output, 1: pipeline execution enable.
REQ-013 SHALL have port o_inst_count, output, MEM_SZ+1: words written since last LOAD command.
REQ-014 SHALL have port o_state, output, 3: current state encoding (IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4).
REQ-015 SHALL have port o_error, output, 1: one-cycle pulse on load abort.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, STEP, DONE; only byte strobes and i_halt cause transitions.
REQ-017 IDLE: byte 0x4C→LOAD (clear o_inst_count, byte index); 0x43→RUN; 0x53→STEP; any other byte ignored.
REQ-018 LOAD: bytes assembled MSB first; 4th byte completes word; o_instruction and o_write=1 on the cycle after the 4th strobe, o_write low the following cycle.
REQ-019 LOAD: each written word increments o_inst_count by 1 in the same cycle o_write is high.
REQ-020 LOAD: written word equal to 0xFFFFFFFF (HALT) SHALL be written, then state→IDLE.
REQ-021 LOAD: when o_inst_count reaches 2^MEM_SZ, state→IDLE; no wrap, no further writes.
REQ-022 RUN: o_enable=1 from the cycle after entry until i_halt samples 1; o_enable=0 the next cycle and state→DONE; bytes ignored in RUN.
REQ-023 STEP: byte 0x4E produces exactly one cycle o_enable=1 on the cycle after the strobe; byte 0x45→IDLE; other bytes ignored.
REQ-024 STEP: i_halt=1 SHALL move state→DONE; pending step pulse still completes.
REQ-025 DONE: o_enable=0; byte 0x52 →IDLE; others ignored; o_inst_count retained.
REQ-026 o_enable SHALL be 0 in IDLE, LOAD, DONE.
REQ-027 i_rx_done and i_halt asserted same cycle in STEP: halt wins, no step pulse issued.

Reset
REQ-028 Asserting i_reset low SHALL immediately force IDLE, o_write=0, o_enable=0, o_error=0, o_instruction=0, o_inst_count=0, byte index=0.
REQ-029 Reset mid-LOAD SHALL discard the partial word; no write generated after release.
REQ-030 Release SHALL take effect synchronously on the next i_clk edge.

Configuration
REQ-031 Macro DEBUG_LOADER_TIMEOUT_EN defined: in LOAD, TIMEOUT cycles without a strobe SHALL discard partial word, pulse o_error one cycle, state→IDLE; counter restarts on every strobe.
REQ-032 Macro DEBUG_LOADER_TIMEOUT_EN undefined: LOAD waits indefinitely; o_error tied 0; no timeout counter present.

Verification
REQ-033 Bytes 4C,12,34,56,78 → one o_write with o_instruction=0x12345678, o_inst_count=1, state LOAD.
REQ-034 After REQ-033, bytes FF,FF,FF,FF → o_write with 0xFFFFFFFF, o_inst_count=2, state IDLE.
REQ-035 Byte 43, i_halt=1 on 10th cycle after entry → o_enable high exactly 10 cycles, then 0, state DONE; byte 52 → IDLE.
REQ-036 Bytes 53,4E,4E,45 → exactly two 1-cycle o_enable pulses, final state IDLE.
REQ-037 Bytes 4C,AA,BB then i_reset low 1 cycle, then 4C,01,02,03,04 → single o_write 0x01020304.
REQ-038 With DEBUG_LOADER_TIMEOUT_EN, TIMEOUT=16: bytes 4C,AA then silence → o_error pulse 16 cycles after AA, state IDLE, no o_write.
